pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush
//  (sync-reset) inputs of the PC, IF/ID, ID/RR and RR/EX pipeline registers.
//  Resolves three conditions: load-use hazards (RR vs EX), taken-branch flush and memory-busy freeze.
//  Sits beside the register file and the pipeline registers; has no datapath of its own.
// PARAMETERS
//  LOAD_OPCODE      6'h23  opcode_EX value that marks a load
//  LU_STALL_CYCLES  1      load-use stall length in cycles, >=1, detection cycle included
//  FLUSH_CYCLES     2      branch flush window in cycles, >=1, detection cycle included
//  CNT_W            32     width of the statistics counters (PIPE_HAZARD_CTRL_STATS_EN only)
// PORTS
//  clk             in   1  rising-edge clock
//  reset           in   1  asynchronous, active-high reset
//  r1_addr_RR      in   5  source register 1 of the instruction in RR
//  r2_addr_RR      in   5  source register 2 of the instruction in RR
//  r1_used_RR      in   1  RR instruction reads r1
//  r2_used_RR      in   1  RR instruction reads r2
//  R3_addr_EX      in   5  destination register of the instruction in EX
//  opcode_EX       in   6  opcode of the instruction in EX
//  branch_taken_EX in   1  branch resolved taken in EX this cycle
//  mem_req_MEM     in   1  data-memory access in progress
//  mem_ack_MEM     in   1  data memory completes the access this cycle
//  en_pc, en_IF_ID, en_ID_RR, en_RR_EX      out 1 each  register enables
//  flush_IF_ID, flush_ID_RR, flush_RR_EX    out 1 each  bubble insert (register sync reset)
//  state_o         out  2  FSM state: 0 RUN, 1 LU_STALL, 2 FLUSH
// BEHAVIOUR
//  - Outputs are combinational from state, counter and inputs.
//  - While reset is high: all en_*=0, all flush_*=0, state=RUN, counter=0.
//  - freeze = mem_req_MEM & ~mem_ack_MEM. Freeze has top priority in every state:
//    all en_*=0, all flush_*=0, state and counter hold.
//  - lu_hit = (opcode_EX==LOAD_OPCODE) & (R3_addr_EX!=0) &
//    ((r1_used_RR & r1_addr_RR==R3_addr_EX) | (r2_used_RR & r2_addr_RR==R3_addr_EX)).
//  - RUN: default is all en_*=1 and flush_*=0.
//    - If branch_taken_EX: flush_IF_ID=flush_ID_RR=1 and all en_*=1 (PC loads the target).
//      If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2.
//    - Else if lu_hit: en_pc=en_IF_ID=en_ID_RR=0, en_RR_EX=1, flush_RR_EX=1 (bubble into EX).
//      If LU_STALL_CYCLES>1, go to LU_STALL with cnt=LU_STALL_CYCLES-2.
//    - A branch and a load-use hit in the same cycle: branch wins, no stall is recorded.
//  - LU_STALL: same outputs as the lu_hit cycle. Branch and lu_hit are ignored.
//    When cnt==0, go to RUN; otherwise cnt decrements.
//  - FLUSH: flush_IF_ID=flush_ID_RR=1, all en_*=1. Branch and lu_hit are ignored.
//    When cnt==0, go to RUN; otherwise cnt decrements.
//  - Reset asserted mid-stall or mid-flush: immediate return to RUN with outputs as stated for reset.
//  - Counter width is $clog2(max(LU_STALL_CYCLES,FLUSH_CYCLES)), minimum 1 bit.
// CONFIGURATION
//  PIPE_HAZARD_CTRL_STATS_EN defined:
//   - Adds outputs stall_cycles_o[CNT_W] and flush_events_o[CNT_W].
//   - stall_cycles_o increments on every cycle with en_pc==0 (freeze or load-use).
//   - flush_events_o increments once per branch detection in RUN.
//   - Both counters saturate at all-ones and clear on reset.
//  Not defined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  pipe_hazard_ctrl_pkg holds:
//   - the state enum (RUN/LU_STALL/FLUSH)
//   - the OPC_LOAD constant
//   - a cnt-width function
//  Sub-module pipe_hazard_stats (the saturating counters) is instantiated only under the macro.
// TESTING
//  1. Load r5 in EX (opcode_EX=6'h23, R3_addr_EX=5) with r1_addr_RR=5, r1_used_RR=1
//     -> one cycle with en_pc=0, flush_RR_EX=1; next cycle all en_*=1.
//  2. LU_STALL_CYCLES=3, same stimulus -> en_pc=0 for exactly 3 cycles; state_o: 0,1,1,0.
//  3. branch_taken_EX=1, FLUSH_CYCLES=2 -> flush_IF_ID=flush_ID_RR=1 for 2 cycles, en_pc=1 throughout.
//  4. Load to R3_addr_EX=0 matching r1_addr_RR=0 -> no stall, all en_*=1.
//  5. mem_req_MEM=1, mem_ack_MEM=0 for 4 cycles during LU_STALL -> all outputs 0, cnt held;
//     after ack the stall resumes the remaining cycles. With stats on, stall_cycles_o includes the 4 cycles.
//  6. Assert reset in FLUSH state -> same cycle all en_*=0, state_o=0; after release all en_*=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// The optional statistics block is enabled by PIPE_HAZARD_CTRL_STATS_EN.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [5:0] OPC_LOAD = 6'h23;

    // Counter width: $clog2 of the longer window, never below one bit.
    function automatic int cnt_width(input int lu_cycles, input int flush_cycles);
        int longest;
        longest = (lu_cycles > flush_cycles) ? lu_cycles : flush_cycles;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, register enables/flushes out.
// Statistics outputs exist only when PIPE_HAZARD_CTRL_STATS_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0] r1_addr_RR;
    logic [4:0] r2_addr_RR;
    logic       r1_used_RR;
    logic       r2_used_RR;
    logic [4:0] R3_addr_EX;
    logic [5:0] opcode_EX;
    logic       branch_taken_EX;
    logic       mem_req_MEM;
    logic       mem_ack_MEM;

    logic       en_pc;
    logic       en_IF_ID;
    logic       en_ID_RR;
    logic       en_RR_EX;
    logic       flush_IF_ID;
    logic       flush_ID_RR;
    logic       flush_RR_EX;
    logic [1:0] state_o;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_events_o;
`endif

    // Pipeline side: reports hazard sources, consumes enables and flushes.
    modport master (
        output r1_addr_RR, r2_addr_RR, r1_used_RR, r2_used_RR,
        output R3_addr_EX, opcode_EX, branch_taken_EX, mem_req_MEM, mem_ack_MEM,
        input  en_pc, en_IF_ID, en_ID_RR, en_RR_EX,
        input  flush_IF_ID, flush_ID_RR, flush_RR_EX, state_o
`ifdef PIPE_HAZARD_CTRL_STATS_EN
        , input stall_cycles_o, flush_events_o
`endif
    );

    modport slave (
        input  r1_addr_RR, r2_addr_RR, r1_used_RR, r2_used_RR,
        input  R3_addr_EX, opcode_EX, branch_taken_EX, mem_req_MEM, mem_ack_MEM,
        output en_pc, en_IF_ID, en_ID_RR, en_RR_EX,
        output flush_IF_ID, flush_ID_RR, flush_RR_EX, state_o
`ifdef PIPE_HAZARD_CTRL_STATS_EN
        , output stall_cycles_o, flush_events_o
`endif
    );

endinterface

// File: rtl/pipe_hazard_stats.sv
// Saturating stall-cycle and flush-event counters for the hazard controller.
// Compiled only when PIPE_HAZARD_CTRL_STATS_EN is defined.
`ifdef PIPE_HAZARD_CTRL_STATS_EN
module pipe_hazard_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the PC, IF/ID, ID/RR and RR/EX pipeline registers.
// Optional statistics counters are added by PIPE_HAZARD_CTRL_STATS_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter logic [5:0] LOAD_OPCODE     = OPC_LOAD,
    parameter int         LU_STALL_CYCLES = 1,
    parameter int         FLUSH_CYCLES    = 2,
    parameter int         CNT_W           = 32
) (
    input logic          clk,
    input logic          reset,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int CW = cnt_width(LU_STALL_CYCLES, FLUSH_CYCLES);

    if (LU_STALL_CYCLES < 1 || FLUSH_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("pipe_hazard_ctrl: window lengths and CNT_W must be at least 1");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          freeze;
    logic          lu_hit;
    logic          r1_hit;
    logic          r2_hit;

    assign freeze = hz.mem_req_MEM & ~hz.mem_ack_MEM;
    assign r1_hit = hz.r1_used_RR & (hz.r1_addr_RR == hz.R3_addr_EX);
    assign r2_hit = hz.r2_used_RR & (hz.r2_addr_RR == hz.R3_addr_EX);
    // r0 is hard-wired zero, so a load to it never creates a dependency.
    assign lu_hit = (hz.opcode_EX == LOAD_OPCODE) & (hz.R3_addr_EX != 5'd0) & (r1_hit | r2_hit);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else if (!freeze) begin
            unique case (state)
                RUN: begin
                    if (hz.branch_taken_EX) begin
                        if (FLUSH_CYCLES > 1) begin
                            state <= FLUSH;
                            cnt   <= CW'(FLUSH_CYCLES - 2);
                        end
                    end else if (lu_hit) begin
                        if (LU_STALL_CYCLES > 1) begin
                            state <= LU_STALL;
                            cnt   <= CW'(LU_STALL_CYCLES - 2);
                        end
                    end
                end
                LU_STALL, FLUSH: begin
                    if (cnt == '0)
                        state <= RUN;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        hz.en_pc       = 1'b0;
        hz.en_IF_ID    = 1'b0;
        hz.en_ID_RR    = 1'b0;
        hz.en_RR_EX    = 1'b0;
        hz.flush_IF_ID = 1'b0;
        hz.flush_ID_RR = 1'b0;
        hz.flush_RR_EX = 1'b0;
        if (!reset && !freeze) begin
            unique case (state)
                RUN: begin
                    hz.en_pc    = 1'b1;
                    hz.en_IF_ID = 1'b1;
                    hz.en_ID_RR = 1'b1;
                    hz.en_RR_EX = 1'b1;
                    if (hz.branch_taken_EX) begin
                        hz.flush_IF_ID = 1'b1;
                        hz.flush_ID_RR = 1'b1;
                    end else if (lu_hit) begin
                        hz.en_pc       = 1'b0;
                        hz.en_IF_ID    = 1'b0;
                        hz.en_ID_RR    = 1'b0;
                        hz.flush_RR_EX = 1'b1;
                    end
                end
                LU_STALL: begin
                    hz.en_RR_EX    = 1'b1;
                    hz.flush_RR_EX = 1'b1;
                end
                FLUSH: begin
                    hz.en_pc       = 1'b1;
                    hz.en_IF_ID    = 1'b1;
                    hz.en_ID_RR    = 1'b1;
                    hz.en_RR_EX    = 1'b1;
                    hz.flush_IF_ID = 1'b1;
                    hz.flush_ID_RR = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.state_o = state;

`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = ~hz.en_pc & ~reset;
    assign flush_inc = (state == RUN) & hz.branch_taken_EX & ~freeze & ~reset;

    pipe_hazard_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .reset        (reset),
        .stall_inc    (stall_inc),
        .flush_inc    (flush_inc),
        .stall_cycles (hz.stall_cycles_o),
        .flush_events (hz.flush_events_o)
    );
`endif

endmodule
